// File: rtl/alu_pkg.sv
// Shared constants for the iterative execute-stage ALU: op codes, FSM states, default widths.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned SHW_DEF   = 5;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0011;
  localparam logic [3:0] SEL_SLT = 4'b0100;
  localparam logic [3:0] SEL_SLL = 4'b0101;
  localparam logic [3:0] SEL_SRL = 4'b0110;
  localparam logic [3:0] SEL_SRA = 4'b0111;
  localparam logic [3:0] SEL_XOR = 4'b1001;
  localparam logic [3:0] SEL_NOR = 4'b1010;
  localparam logic [3:0] SEL_NOP = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between the issue logic and the iterative ALU.
interface alu_iter_if #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH_DEF,
  parameter int unsigned SHW   = alu_pkg::SHW_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, sel, a, b, shamt,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, sel, a, b, shamt,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle datapath: logic, add/sub, signed compare and overflow. Shift codes pass b (shift by 0).
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c,
  output logic             ovf_c
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Sign of the difference corrected by overflow gives a full-range signed less-than.
  assign lt      = diff[WIDTH-1] ^ ovf_sub;

  // Result and overflow select by op code.
  always_comb begin
    y_c   = '0;
    ovf_c = 1'b0;
    case (sel)
      SEL_AND: y_c = a & b;
      SEL_OR:  y_c = a | b;
      SEL_ADD: begin y_c = sum;  ovf_c = ovf_add; end
      SEL_SUB: begin y_c = diff; ovf_c = ovf_sub; end
      SEL_SLT: y_c = WIDTH'(lt);
      SEL_SLL, SEL_SRL, SEL_SRA: y_c = b;
      SEL_XOR: y_c = a ^ b;
      SEL_NOR: y_c = ~(a | b);
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle ops through alu_comb, shifts iterate one bit per cycle.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] comb_y;
  logic             comb_ovf;
  logic [WIDTH-1:0] acc_step;
  logic             accept;
  logic             is_shift;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .sel   (bus.sel),
    .a     (bus.a),
    .b     (bus.b),
    .y_c   (comb_y),
    .ovf_c (comb_ovf)
  );

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

  assign accept   = bus.in_valid && (state_q == S_IDLE);
  assign is_shift = (bus.sel == SEL_SLL) || (bus.sel == SEL_SRL) || (bus.sel == SEL_SRA);

  // One-bit shift of the accumulator in the latched direction (sel[1:0]: 01 SLL, 10 SRL, 11 SRA).
  always_comb begin
    case (dir_q)
      2'b01:   acc_step = {acc_q[WIDTH-2:0], 1'b0};
      2'b10:   acc_step = {1'b0, acc_q[WIDTH-1:1]};
      default: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_shift && (bus.shamt != '0)) begin
            acc_d   = bus.b;
            cnt_d   = bus.shamt;
            dir_d   = bus.sel[1:0];
            state_d = S_SHIFT;
          end else begin
            result_d    = comb_y;
            zero_d      = (comb_y == '0);
            ovf_d       = comb_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d    = acc_step;
          zero_d      = (acc_step == '0);
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 2'b00;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter.
module tb_alu_iter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_iter_if #(.WIDTH(32), .SHW(5)) bus ();

  alu_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic z, input logic ov);
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".res"}, bus.result, res);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(z));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ov));
  endtask

  // Present one request for a single cycle; returns in cycle 1.
  task automatic issue(input logic [3:0] s, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh);
    bus.sel      = s;
    bus.a        = aa;
    bus.b        = bb;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel      = SEL_NOP;
    bus.a        = '0;
    bus.b        = '0;
    bus.shamt    = '0;
    tick();
    tick();
    chk("rst.rdy", 32'(bus.in_ready), 32'd1);
    chk("rst.vld", 32'(bus.out_valid), 32'd0);
    chk("rst.res", bus.result, 32'h0);
    chk("rst.zero", 32'(bus.zero), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    issue(SEL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    issue(SEL_SUB, 32'h0000_1234, 32'h0000_1234, 5'd0);
    chk_out("sub_zero", 32'h0, 1'b1, 1'b0);
    issue(SEL_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
    issue(SEL_SLT, 32'h8000_0000, 32'h0000_0001, 5'd0);
    chk_out("slt_neg", 32'h1, 1'b0, 1'b0);
    issue(SEL_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    chk_out("slt_pos", 32'h0, 1'b1, 1'b0);
    issue(SEL_OR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    chk_out("or", 32'h0F0F_00F0, 1'b0, 1'b0);
    issue(SEL_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0);
    chk_out("xor", 32'h5A5A_A5A5, 1'b0, 1'b0);
    issue(SEL_NOR, 32'h0, 32'h0, 5'd0);
    chk_out("nor", 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    chk("idle.vld", 32'(bus.out_valid), 32'd0);

    // SRA by 4: busy in cycles 1..4, result in cycle 5.
    issue(SEL_SRA, 32'h0, 32'h8000_0000, 5'd4);
    for (int c = 1; c <= 4; c++) begin
      chk("sra.busy", 32'(bus.in_ready), 32'd0);
      chk("sra.novld", 32'(bus.out_valid), 32'd0);
      tick();
    end
    chk_out("sra", 32'hF800_0000, 1'b0, 1'b0);
    chk("sra.rdy", 32'(bus.in_ready), 32'd1);

    // SRL by 31 with an ignored AND request held during the shift.
    issue(SEL_SRL, 32'h0, 32'hFFFF_FFFF, 5'd31);
    bus.sel      = SEL_AND;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    bus.in_valid = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      if (c == 31) bus.in_valid = 1'b0;
      chk("srl.busy", 32'(bus.in_ready), 32'd0);
      chk("srl.novld", 32'(bus.out_valid), 32'd0);
      tick();
    end
    chk_out("srl", 32'h0000_0001, 1'b0, 1'b0);
    tick();
    chk("srl.after.vld", 32'(bus.out_valid), 32'd0);
    chk("srl.after.res", bus.result, 32'h0000_0001);

    issue(SEL_SLL, 32'h0, 32'h0000_0005, 5'd0);
    chk_out("sll0", 32'h0000_0005, 1'b0, 1'b0);
    chk("sll0.rdy", 32'(bus.in_ready), 32'd1);

    // Three back-to-back ADDs.
    bus.sel      = SEL_ADD;
    bus.shamt    = '0;
    bus.in_valid = 1'b1;
    bus.a = 32'd1;  bus.b = 32'd1;
    tick();
    chk_out("b2b0", 32'd2, 1'b0, 1'b0);
    chk("b2b0.rdy", 32'(bus.in_ready), 32'd1);
    bus.a = 32'd2;  bus.b = 32'd3;
    tick();
    chk_out("b2b1", 32'd5, 1'b0, 1'b0);
    chk("b2b1.rdy", 32'(bus.in_ready), 32'd1);
    bus.a = 32'd10; bus.b = 32'd20;
    tick();
    chk_out("b2b2", 32'd30, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("b2b.end.vld", 32'(bus.out_valid), 32'd0);

    // Reset in cycle 3 of a 10-bit SLL aborts it.
    issue(SEL_SLL, 32'h0, 32'h0000_0001, 5'd10);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort.rdy", 32'(bus.in_ready), 32'd1);
    chk("abort.res", bus.result, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      chk("abort.novld", 32'(bus.out_valid), 32'd0);
      tick();
    end
    chk("abort.idle.res", bus.result, 32'h0);
    issue(SEL_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    chk_out("and", 32'hF000_F000, 1'b0, 1'b0);

    // Undefined and NOP codes, each following a result with overflow set.
    issue(SEL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    chk_out("add_ovf2", 32'h8000_0000, 1'b0, 1'b1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    chk_out("undef", 32'h0, 1'b1, 1'b0);
    issue(SEL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    issue(SEL_NOP, 32'h1234_5678, 32'h0000_0001, 5'd3);
    chk_out("nop", 32'h0, 1'b1, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
